// File: rtl/pe_pkg.sv
// Default geometry of the linear MAC processing-element row.
package pe_pkg;
    localparam int DEF_N_PE  = 4;
    localparam int DEF_A_W   = 8;
    localparam int DEF_W_W   = 8;
    localparam int DEF_ACC_W = 12;
endpackage

// File: rtl/pe_lin_gen_if.sv
// Parent-facing bundle of the PE row: activation stream, stationary weights, accumulators.
interface pe_lin_gen_if
    import pe_pkg::*;
#(
    parameter int N_PE  = DEF_N_PE,
    parameter int A_W   = DEF_A_W,
    parameter int W_W   = DEF_W_W,
    parameter int ACC_W = DEF_ACC_W
) ();
    logic             fire;
    logic [A_W-1:0]   in_a;
    logic [W_W-1:0]   in_w [N_PE];
    logic [ACC_W-1:0] outs [N_PE];

    modport master (output fire, output in_a, output in_w, input outs);
    modport slave  (input fire, input in_a, input in_w, output outs);
endinterface

// File: rtl/pe_lin_cell.sv
// One processing element: registers the passing activation/valid and accumulates a*w.
module pe_lin_cell
    import pe_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int W_W   = DEF_W_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [A_W-1:0]   i_a,
    input  logic             i_vld,
    input  logic [W_W-1:0]   i_w,
    output logic [A_W-1:0]   o_a,
    output logic             o_vld,
    output logic [ACC_W-1:0] o_acc
);
    localparam int PROD_W = A_W + W_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    logic [A_W-1:0]   r_a_p0;
    logic             r_vld_p0;
    logic [ACC_W-1:0] r_acc_p1;

    // Full-precision product, sum wraps modulo 2^ACC_W (no saturation by design).
    function automatic logic [ACC_W-1:0] mac_wrap(
        input logic [ACC_W-1:0] acc,
        input logic [A_W-1:0]   a,
        input logic [W_W-1:0]   w
    );
        logic [PROD_W-1:0] prod;
        logic [SUM_W-1:0]  sum;
        prod = PROD_W'(a) * PROD_W'(w);
        sum  = SUM_W'(acc) + SUM_W'(prod);
        return sum[ACC_W-1:0];
    endfunction

    // Stage p0: activation/valid register; stage p1: accumulator.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a_p0   <= '0;
            r_vld_p0 <= 1'b0;
            r_acc_p1 <= '0;
        end else begin
            r_a_p0   <= i_a;
            r_vld_p0 <= i_vld;
            if (r_vld_p0) begin
                r_acc_p1 <= mac_wrap(r_acc_p1, r_a_p0, i_w);
            end
        end
    end

    assign o_a   = r_a_p0;
    assign o_vld = r_vld_p0;
    assign o_acc = r_acc_p1;
endmodule

// File: rtl/pe_lin_gen.sv
// Linear systolic row of N_PE weight-stationary MAC cells; activations shift one PE per clock.
module pe_lin_gen
    import pe_pkg::*;
#(
    parameter int N_PE  = DEF_N_PE,
    parameter int A_W   = DEF_A_W,
    parameter int W_W   = DEF_W_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic         clk,
    input  logic         rstn,
    pe_lin_gen_if.slave  bus
);
    // Element k feeds cell k; the final element is the unexported tail of the chain.
    logic [A_W-1:0] w_a_chain   [N_PE+1];
    logic           w_vld_chain [N_PE+1];

    assign w_a_chain[0]   = bus.in_a;
    assign w_vld_chain[0] = bus.fire;

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        pe_lin_cell #(
            .A_W   (A_W),
            .W_W   (W_W),
            .ACC_W (ACC_W)
        ) u_cell (
            .clk   (clk),
            .rstn  (rstn),
            .i_a   (w_a_chain[k]),
            .i_vld (w_vld_chain[k]),
            .i_w   (bus.in_w[k]),
            .o_a   (w_a_chain[k+1]),
            .o_vld (w_vld_chain[k+1]),
            .o_acc (bus.outs[k])
        );
    end
endmodule

// File: tb/tb_pe_lin_gen.sv
// Directed bench for pe_lin_gen: expected accumulator vectors queued on drive, popped on check.
module tb_pe_lin_gen;
    import pe_pkg::*;

    localparam int N    = DEF_N_PE;
    localparam int AW   = DEF_A_W;
    localparam int WW   = DEF_W_W;
    localparam int ACCW = DEF_ACC_W;
    localparam int VW   = N * ACCW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    pe_lin_gen_if #(.N_PE(N), .A_W(AW), .W_W(WW), .ACC_W(ACCW)) bus ();

    pe_lin_gen #(.N_PE(N), .A_W(AW), .W_W(WW), .ACC_W(ACCW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic [VW-1:0]  val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [VW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {ACCW'(e3), ACCW'(e2), ACCW'(e1), ACCW'(e0)};
    endfunction

    function automatic logic [VW-1:0] obs();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*ACCW +: ACCW] = bus.outs[k];
        return v;
    endfunction

    task automatic push(input string tag, input logic [VW-1:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t          e;
        logic [VW-1:0] o;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed no queued expectation, required one");
        end else begin
            e = sb.pop_front();
            o = obs();
            assert (o === e.val)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic cyc(input int f, input int a);
        bus.fire = (f != 0);
        bus.in_a = AW'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        bus.in_w[0] = WW'(w0);
        bus.in_w[1] = WW'(w1);
        bus.in_w[2] = WW'(w2);
        bus.in_w[3] = WW'(w3);
    endtask

    task automatic do_reset(input string tag);
        bus.fire = 1'b0;
        rstn = 1'b0;
        #1;
        push(tag, pk(0, 0, 0, 0));
        check();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        bus.fire = 1'b0;
        bus.in_a = '0;
        set_w(0, 0, 0, 0);
        #1;
        push("reset_init", pk(0, 0, 0, 0));
        check();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        push("idle_after_release", pk(0, 0, 0, 0));
        check();

        // Basic stream
        set_w(0, 1, 2, 3);
        push("basic_e1", pk(0, 0, 0, 0));
        cyc(1, 1);
        check();
        push("basic_o1_e2", pk(0, 0, 0, 0));
        cyc(1, 2);
        check();
        push("basic_o1_e3", pk(0, 1, 0, 0));
        cyc(1, 3);
        check();
        for (int i = 4; i <= 8; i++) cyc(1, i);
        push("basic_final", pk(0, 36, 72, 108));
        for (int i = 0; i < 4; i++) cyc(0, 0);
        check();

        // Reset with nonzero accumulators and data in flight
        cyc(1, 9);
        cyc(1, 9);
        do_reset("reset_midstream");
        push("reset_flush", pk(0, 0, 0, 0));
        for (int i = 0; i < 5; i++) cyc(0, 0);
        check();

        // Skew: single pulse steps each PE one edge later
        set_w(1, 1, 1, 1);
        push("skew_e0", pk(0, 0, 0, 0));
        cyc(1, 5);
        check();
        for (int i = 1; i <= 5; i++) begin
            push($sformatf("skew_e%0d", i),
                 pk((i >= 1) ? 5 : 0, (i >= 2) ? 5 : 0, (i >= 3) ? 5 : 0, (i >= 4) ? 5 : 0));
            cyc(0, 0);
            check();
        end

        // Bubble: the 99 must never be accumulated
        do_reset("reset_pre_bubble");
        cyc(1, 3);
        cyc(0, 99);
        cyc(1, 4);
        push("bubble_final", pk(7, 7, 7, 7));
        for (int i = 0; i < 4; i++) cyc(0, 0);
        check();

        // Wrap modulo 2^ACC_W
        do_reset("reset_pre_wrap");
        set_w(255, 255, 255, 255);
        cyc(1, 255);
        push("wrap_first", pk(3585, 3585, 3585, 3585));
        for (int i = 0; i < 4; i++) cyc(0, 0);
        check();
        cyc(1, 255);
        push("wrap_second", pk(3074, 3074, 3074, 3074));
        for (int i = 0; i < 4; i++) cyc(0, 0);
        check();

        // Idle hold with random activations on the bus
        for (int i = 0; i < 20; i++) begin
            push($sformatf("idle_hold_%0d", i), pk(3074, 3074, 3074, 3074));
            cyc(0, int'($urandom_range(0, 255)));
            check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
